// File: rtl/enc_pkg.sv
// Shared types and widths for the 8-to-3 sequential encoder.
package enc_pkg;

    localparam int unsigned SEL_W  = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_e;

endpackage

// File: rtl/enc_prio8.sv
// Combinational priority finder: index of the lowest (or highest) set bit, plus a
// flag that is set when exactly one bit is set.
module enc_prio8
    import enc_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [SEL_W-1:0]  pending,
    output logic [ADDR_W-1:0] index,
    output logic              single
);

    always_comb begin
        index = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(SEL_W); i++) begin
                if (pending[i]) index = ADDR_W'(i);
            end
        end else begin
            for (int i = int'(SEL_W) - 1; i >= 0; i--) begin
                if (pending[i]) index = ADDR_W'(i);
            end
        end
    end

    // Non-zero and clearing the lowest set bit leaves nothing.
    assign single = (pending != '0) && ((pending & (pending - SEL_W'(1))) == '0);

endmodule

// File: rtl/encoder8to3.sv
// Sequential 8-to-3 encoder: emits the index of every set selector bit, one per beat.
// Optional macro ENC_ZERO_ERR_EN adds o_err, a one-cycle pulse after a zero vector.
module encoder8to3
    import enc_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel_valid,
    input  logic [SEL_W-1:0]  i_selector,
    output logic              o_sel_ready,
    output logic              o_addr_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    input  logic              i_addr_ready,
`ifdef ENC_ZERO_ERR_EN
    output logic              o_err,
`endif
    output logic              o_busy
);

    enc_state_e        state_q, state_d;
    logic [SEL_W-1:0]  pending_q, pending_d;
    logic [ADDR_W-1:0] idx;
    logic              single;
    logic              sel_fire;
    logic              addr_fire;

    enc_prio8 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .pending (pending_q),
        .index   (idx),
        .single  (single)
    );

    assign o_sel_ready  = (state_q == IDLE);
    assign o_addr_valid = (state_q == SCAN);
    assign o_busy       = (state_q == SCAN);
    assign o_addr       = o_addr_valid ? idx : '0;
    assign o_last       = o_addr_valid & single;

    assign sel_fire  = i_sel_valid & o_sel_ready;
    assign addr_fire = o_addr_valid & i_addr_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (sel_fire && (i_selector != '0)) begin
                    pending_d = i_selector;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (addr_fire) begin
                    pending_d = pending_q & ~(SEL_W'(1) << idx);
                    if (single) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef ENC_ZERO_ERR_EN
    logic err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= sel_fire && (i_selector == '0);
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_encoder8to3.sv
// Bench for encoder8to3: both scan orders side by side against a queue-based model.
module tb_encoder8to3;

    logic       clk;
    logic       rst;
    logic       sel_valid;
    logic [7:0] selector;
    logic       addr_ready;

    logic       ready_l, valid_l, last_l, busy_l;
    logic [2:0] addr_l;
    logic       ready_m, valid_m, last_m, busy_m;
    logic [2:0] addr_m;
`ifdef ENC_ZERO_ERR_EN
    logic       err_l, err_m;
`endif

    int checks   = 0;
    int failures = 0;

    encoder8to3 #(.MSB_FIRST(1'b0)) dut_lsb (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sel_valid  (sel_valid),
        .i_selector   (selector),
        .o_sel_ready  (ready_l),
        .o_addr_valid (valid_l),
        .o_addr       (addr_l),
        .o_last       (last_l),
        .i_addr_ready (addr_ready),
`ifdef ENC_ZERO_ERR_EN
        .o_err        (err_l),
`endif
        .o_busy       (busy_l)
    );

    encoder8to3 #(.MSB_FIRST(1'b1)) dut_msb (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sel_valid  (sel_valid),
        .i_selector   (selector),
        .o_sel_ready  (ready_m),
        .o_addr_valid (valid_m),
        .o_addr       (addr_m),
        .o_last       (last_m),
        .i_addr_ready (addr_ready),
`ifdef ENC_ZERO_ERR_EN
        .o_err        (err_m),
`endif
        .o_busy       (busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the remaining beats of the current vector, in emission order.
    int q_lsb[$];
    int q_msb[$];
    logic err_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_lsb.delete();
            q_msb.delete();
            err_exp <= 1'b0;
        end else begin
            err_exp <= sel_valid && (q_lsb.size() == 0) && (selector == 8'h00);
            if (q_lsb.size() == 0) begin
                if (sel_valid) begin
                    for (int b = 0; b < 8; b++) if (selector[b]) q_lsb.push_back(b);
                    for (int b = 7; b >= 0; b--) if (selector[b]) q_msb.push_back(b);
                end
            end else if (addr_ready) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        check("lsb_ready", int'(ready_l), int'(q_lsb.size() == 0));
        check("lsb_valid", int'(valid_l), int'(q_lsb.size() != 0));
        check("lsb_busy",  int'(busy_l),  int'(q_lsb.size() != 0));
        check("msb_ready", int'(ready_m), int'(q_msb.size() == 0));
        check("msb_valid", int'(valid_m), int'(q_msb.size() != 0));
        check("msb_busy",  int'(busy_m),  int'(q_msb.size() != 0));
        if (q_lsb.size() != 0) begin
            check("lsb_addr", int'(addr_l), q_lsb[0]);
            check("lsb_last", int'(last_l), int'(q_lsb.size() == 1));
        end
        if (q_msb.size() != 0) begin
            check("msb_addr", int'(addr_m), q_msb[0]);
            check("msb_last", int'(last_m), int'(q_msb.size() == 1));
        end
`ifdef ENC_ZERO_ERR_EN
        check("lsb_err", int'(err_l), int'(err_exp));
        check("msb_err", int'(err_m), int'(err_exp));
`endif
    end

    // Offer a vector for one cycle; returns at the negedge of the first beat cycle.
    task automatic send(input logic [7:0] vec);
        sel_valid = 1'b1;
        selector  = vec;
        @(negedge clk);
        sel_valid = 1'b0;
        selector  = 8'h00;
    endtask

    task automatic expect_beat(input string name, input int al, input int am, input int last);
        check({name, "_valid"}, int'(valid_l & valid_m), 1);
        check({name, "_addr_lsb"}, int'(addr_l), al);
        check({name, "_addr_msb"}, int'(addr_m), am);
        check({name, "_last_lsb"}, int'(last_l), last);
        check({name, "_last_msb"}, int'(last_m), last);
    endtask

    task automatic expect_idle(input string name);
        check({name, "_ready"}, int'(ready_l & ready_m), 1);
        check({name, "_valid"}, int'(valid_l | valid_m), 0);
        check({name, "_busy"},  int'(busy_l | busy_m), 0);
    endtask

    int vec_l[4]  = '{1, 2, 5, 7};
    int vec_m[4]  = '{7, 5, 2, 1};
    int stall_r[6] = '{1, 0, 0, 1, 1, 1};
    int stall_l[6] = '{1, 2, 2, 2, 5, 7};
    int stall_m[6] = '{7, 5, 5, 5, 2, 1};

    initial begin
        rst        = 1'b1;
        sel_valid  = 1'b0;
        selector   = 8'h00;
        addr_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_idle("reset");

        // Single bit.
        send(8'b0000_0100);
        expect_beat("one_hot", 2, 2, 1);
        @(negedge clk);
        expect_idle("one_hot_done");

        // Multi-hot, ready held high.
        send(8'b1010_0110);
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("multi%0d", i), vec_l[i], vec_m[i], int'(i == 3));
            @(negedge clk);
        end
        expect_idle("multi_done");

        // Same vector with consumer stalls.
        send(8'b1010_0110);
        for (int i = 0; i < 6; i++) begin
            addr_ready = stall_r[i][0];
            expect_beat($sformatf("stall%0d", i), stall_l[i], stall_m[i], int'(i == 5));
            @(negedge clk);
        end
        addr_ready = 1'b1;
        expect_idle("stall_done");

        // Reset in the middle of a full vector.
        send(8'hFF);
        for (int i = 0; i < 3; i++) begin
            expect_beat($sformatf("full%0d", i), i, 7 - i, 0);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        expect_idle("midrst");
        check("midrst_addr", int'(addr_l | addr_m), 0);
        check("midrst_last", int'(last_l | last_m), 0);
`ifdef ENC_ZERO_ERR_EN
        check("midrst_err", int'(err_l | err_m), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_idle("after_rst");
        send(8'b0000_0001);
        expect_beat("after_rst_bit0", 0, 0, 1);
        @(negedge clk);
        expect_idle("after_rst_done");

        // Zero vector: consumed without a beat.
        send(8'h00);
        expect_idle("zero");
`ifdef ENC_ZERO_ERR_EN
        check("zero_err_pulse", int'(err_l & err_m), 1);
`endif
        @(negedge clk);
        expect_idle("zero_after");
`ifdef ENC_ZERO_ERR_EN
        check("zero_err_clear", int'(err_l | err_m), 0);
`endif

        // Back-to-back: vector of k bits takes k+1 cycles to the next acceptance.
        send(8'b1000_0001);
        expect_beat("b2b0", 0, 7, 0);
        @(negedge clk);
        expect_beat("b2b1", 7, 0, 1);
        @(negedge clk);
        send(8'b0001_0000);
        expect_beat("b2b2", 4, 4, 1);
        @(negedge clk);
        expect_idle("b2b_done");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
